// File: rtl/vehicle_call_conditioner.sv
// vehicle_call_conditioner
// Conditions the three raw loop-detector inputs (ch1 NB 4th Ave, ch2 EB Harrison,
// ch3 WB Harrison) into latched call requests S1..S3 for the TrafficLights FSM.
// Each channel: 2-flop synchroniser -> debounce counter -> call FSM that holds
// the call until the controller reports green on that approach (L == 01).
//
// Build option: define STUCK_DETECT_EN to add a per-channel stuck-detector
// counter. A detector that stays debounced-high for STUCK_CYCLES sets a sticky
// Fault bit and forces that channel's call high (fail-safe recall). Without the
// macro no stuck counters exist and Fault is tied to zero.
//
// dbg_state exposes the three call FSM states, two bits per channel
// (bits [1:0] = ch1): 00 IDLE, 01 CALL, 10 SERVED.
module vehicle_call_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Raw1,
    input  logic       Raw2,
    input  logic       Raw3,
    input  logic [1:0] L1,
    input  logic [1:0] L2,
    input  logic [1:0] L3,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic [2:0] Fault,
    output logic [5:0] dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALL   = 2'd1;
    localparam logic [1:0] ST_SERVED = 2'd2;

    localparam logic [1:0] LIGHT_GREEN = 2'b01;

    // Terminal count of the debounce counter: a change is accepted on the
    // cycle where the counter already holds DEBOUNCE_CYCLES-1.
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 || STUCK_CYCLES < 1) begin : g_bad_param
        $error("vehicle_call_conditioner: DEBOUNCE_CYCLES must be 2..255 and STUCK_CYCLES >= 1");
    end

    logic [2:0] raw_vec;
    logic [1:0] light_vec [3];
    logic [2:0] s_vec;
    logic [2:0] fault_vec;

    assign raw_vec      = {Raw3, Raw2, Raw1};
    assign light_vec[0] = L1;
    assign light_vec[1] = L2;
    assign light_vec[2] = L3;

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic       sync_a;
        logic       sync_b;
        logic       deb;
        logic [7:0] cnt;
        logic [1:0] state;
        logic [1:0] state_next;
        logic       green;
        logic       call_next;
        logic       s_q;
        logic       fault_q;
        logic       fault_next;

        // Any code other than 01 (red, yellow, reserved) is treated as not green.
        assign green = (light_vec[ch] == LIGHT_GREEN);

        // Two-flop synchroniser for the asynchronous detector input.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                sync_a <= 1'b0;
                sync_b <= 1'b0;
            end else begin
                sync_a <= raw_vec[ch];
                sync_b <= sync_a;
            end
        end

        // Debounce: accept a level change only after it has been stable for
        // DEBOUNCE_CYCLES consecutive synchronised cycles.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                cnt <= 8'd0;
                deb <= 1'b0;
            end else if (sync_b == deb) begin
                cnt <= 8'd0;
            end else if (cnt == DEB_LAST) begin
                deb <= ~deb;
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end

        // Call FSM next-state: latch a call until served, treat deb as an
        // extension request while green, and re-call if still occupied on red.
        always_comb begin
            state_next = state;
            case (state)
                ST_IDLE: begin
                    if (deb) begin
                        state_next = green ? ST_SERVED : ST_CALL;
                    end
                end
                ST_CALL: begin
                    if (green) begin
                        state_next = ST_SERVED;
                    end
                end
                ST_SERVED: begin
                    if (!green) begin
                        state_next = deb ? ST_CALL : ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        // The call is asserted in CALL, and in SERVED only while the detector
        // is still occupied.
        assign call_next = (state_next == ST_CALL) ||
                           ((state_next == ST_SERVED) && deb);

`ifdef STUCK_DETECT_EN
        localparam int SW = $clog2(STUCK_CYCLES + 1);
        localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);
        localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

        logic [SW-1:0] stuck_cnt;

        // Fault sets on the edge the stuck counter reaches STUCK_CYCLES and
        // stays set until reset.
        assign fault_next = fault_q || (deb && (stuck_cnt == STUCK_LAST));

        // Stuck counter: counts consecutive debounced-high cycles, saturating
        // at STUCK_CYCLES; fault flag is sticky.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                stuck_cnt <= '0;
                fault_q   <= 1'b0;
            end else begin
                fault_q <= fault_next;
                if (!deb) begin
                    stuck_cnt <= '0;
                end else if (stuck_cnt != STUCK_MAX) begin
                    stuck_cnt <= stuck_cnt + 1'b1;
                end
            end
        end
`else
        assign fault_q    = 1'b0;
        assign fault_next = 1'b0;
`endif

        // State register and registered call output; a stuck fault forces a
        // recall while the FSM keeps tracking the approach normally.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                state <= ST_IDLE;
                s_q   <= 1'b0;
            end else begin
                state <= state_next;
                s_q   <= call_next || fault_next;
            end
        end

        assign s_vec[ch]            = s_q;
        assign fault_vec[ch]        = fault_q;
        assign dbg_state[2*ch +: 2] = state;
    end

    assign S1    = s_vec[0];
    assign S2    = s_vec[1];
    assign S3    = s_vec[2];
    assign Fault = fault_vec;

endmodule

// File: doc/vehicle_call_conditioner.md
Name: vehicle_call_conditioner

Overview:
- Upstream stage of the TrafficLights FSM, driving its S1/S2/S3 sensor inputs.
- Takes raw, asynchronous, bouncy loop-detector signals for NB 4th Ave (ch1), EB Harrison (ch2) and WB Harrison (ch3).
- Per channel: synchronises, debounces and latches each input as a "call".
- Holds each call until the controller serves that approach, using its L1/L2/L3 outputs as feedback.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a level change (legal range 2..255)
STUCK_CYCLES, 1024, consecutive debounced-high cycles that flag a stuck detector (used only with STUCK_DETECT_EN)

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Raw1  input  1  raw detector, NB SW 4th Ave; asynchronous
Raw2  input  1  raw detector, EB SW Harrison St; asynchronous
Raw3  input  1  raw detector, WB SW Harrison St; asynchronous
L1  input  2  light feedback, ch1 (00 red, 01 green, 10 yellow, 11 reserved)
L2  input  2  light feedback, ch2, same encoding
L3  input  2  light feedback, ch3, same encoding
S1  output  1  conditioned call, ch1; registered
S2  output  1  conditioned call, ch2; registered
S3  output  1  conditioned call, ch3; registered
Fault  output  3  per-channel stuck-detector flag, bit0 = ch1; registered

Behaviour:
- Three identical, independent channels. Reset is sampled only on the rising edge of Clock.
- Reset while Reset=1:
  - sync flops, debounced level, debounce counter and stuck counter go to 0.
  - call FSM goes to IDLE; S1..S3 = 0; Fault = 0.
  - Reset mid-operation discards pending calls and debounce progress.
- Synchroniser: 2-flop chain on each RawN, giving syncN.
- Debounce, per channel (8-bit counter cnt, debounced level deb):
  - syncN == deb: cnt cleared to 0.
  - syncN != deb and cnt == DEBOUNCE_CYCLES-1: deb toggles, cnt cleared.
  - otherwise cnt increments.
  - Pulses shorter than DEBOUNCE_CYCLES synchronised cycles have no effect.
- Green for a channel means L == 01. Values 00, 10 and 11 all count as not green.
- Call FSM, per channel; states IDLE, CALL, SERVED:
  - IDLE: S=0. deb=1 and green goes to SERVED. deb=1 and not green goes to CALL.
  - CALL: S=1 and stays 1 even if deb falls (latched call). Green goes to SERVED.
  - SERVED: S=deb, which acts as an extension request while green. On leaving green: deb=1 goes to CALL, deb=0 goes to IDLE.
  - Simultaneous deb rise and green-entry: go straight to SERVED.
  - S is the registered output of the state and deb.
- Latency: count the first rising edge where RawN is sampled high as edge 1.
  - deb rises at edge 2+DEBOUNCE_CYCLES.
  - S rises at edge 3+DEBOUNCE_CYCLES (edge 7 by default).
  - Falling path (SERVED state, deb dropping) has the same latency.
- Channels never interact. All three may call at once.

Optional Feature:
- Macro: STUCK_DETECT_EN.
- Defined:
  - Each channel has a stuck counter, width $clog2(STUCK_CYCLES+1), which increments while deb=1 and clears when deb=0.
  - When the counter reaches STUCK_CYCLES, the Fault bit sets. Fault is sticky until Reset.
  - While Fault is set, S is forced to 1 (fail-safe recall) whatever the FSM state; the FSM keeps running.
- Undefined:
  - No stuck counters are built; Fault is tied to 3'b000.
  - S follows the call FSM only.

Test Plan:
- Reset held for 2 cycles, then released, all RawN=0 and L=00: S1..S3=0 and Fault=0 on every cycle.
- Raw1 rises and stays high, DEBOUNCE_CYCLES=4, L1=00: S1=1 at edge 7 and not before; S2 and S3 stay 0.
- Raw2 glitches high for 3 cycles then low: S2 never asserts. Repeat with a 6-cycle pulse and L2=00: S2 latches 1 and stays 1 after Raw2 drops.
- Ch3 latched in CALL, then L3 driven to 01 with Raw3 low:
  - S3 falls to 0 on the edge after green is seen.
  - L3 then set to 10 with Raw3 high for 10 cycles beforehand: S3=1 persists into CALL.
- Reset asserted while all three channels are in CALL: next edge gives S1..S3=0 and counters cleared. A Raw1 assertion after release again needs the full 7 edges.
- With STUCK_DETECT_EN and STUCK_CYCLES=16: Raw1 held high, L1 cycling 01 then 00.
  - Fault[0]=1 sixteen cycles after deb rises; S1=1 while L1=01 regardless of deb.
  - Fault stays 1 after Raw1 drops, until Reset.
  - Without the macro the same stimulus gives Fault=000.
